// File: rtl/mic_adc_capture.sv
// Paces ADC conversions at SAMPLE_DIV, reads a 12-bit serial ADC over 3-wire SPI, emits signed 16-bit PCM.
// Latency: Sample_Valid rises 34*SCLK_DIV+1 Clk after the Cs_n falling edge.
// Backpressure: none; Sample_Valid is a one-Clk strobe, and a tick during a busy frame is dropped and flags Overrun.
// Optional: define MIC_AVG2_EN to output the mean of the current and previous samples.
module mic_adc_capture #(
    parameter int SCLK_DIV   = 8,
    parameter int SAMPLE_DIV = 6250
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic        Miso,
    output logic        Sclk,
    output logic        Cs_n,
    output logic [15:0] Audio_Sample,
    output logic        Sample_Valid,
    output logic        Overrun
);

    localparam int TW = $clog2(SAMPLE_DIV + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, QUIET, DONE} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tmr;
    logic          tick;
    logic [7:0]    div_cnt, div_cnt_nx;
    logic          div_end;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    // Only the last 12 bits of the 16-bit frame are kept; the four leading
    // zeros from the ADC simply shift out of the top of this register.
    logic [11:0]   raw, raw_nx;
    logic          sclk_nx, cs_n_nx, ovr_nx, valid_nx;
    logic [15:0]   sample_nx;
    logic [15:0]   conv;
    logic [15:0]   result;

    // Offset binary to two's complement, left-justified to 16 bits.
    assign conv    = {~raw[11], raw[10:0], 4'b0000};
    assign tick    = (tmr == TW'(SAMPLE_DIV - 1)) && En;
    assign div_end = (div_cnt == 8'(SCLK_DIV - 1));

`ifdef MIC_AVG2_EN
    logic [15:0] prev;

    // Two-tap mean over a 17-bit signed sum; truncation keeps sum[16:1].
    assign result = 16'(({conv[15], conv} + {prev[15], prev}) >> 1);

    // Remember the unaveraged sample for the next frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            prev <= '0;
        else if (state == DONE)
            prev <= conv;
    end
`else
    assign result = conv;
`endif

    // Free-running sample-period timer; runs whether or not En is set.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            tmr <= '0;
        else if (tmr == TW'(SAMPLE_DIV - 1))
            tmr <= '0;
        else
            tmr <= tmr + TW'(1);
    end

    // State and registered output update.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            raw          <= '0;
            Sclk         <= 1'b1;
            Cs_n         <= 1'b1;
            Audio_Sample <= '0;
            Sample_Valid <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            state        <= state_nx;
            div_cnt      <= div_cnt_nx;
            bit_cnt      <= bit_cnt_nx;
            raw          <= raw_nx;
            Sclk         <= sclk_nx;
            Cs_n         <= cs_n_nx;
            Audio_Sample <= sample_nx;
            Sample_Valid <= valid_nx;
            Overrun      <= ovr_nx;
        end
    end

    // Frame sequencing: next state and next values of the SPI pins and outputs.
    always_comb begin
        state_nx   = state;
        div_cnt_nx = div_cnt;
        bit_cnt_nx = bit_cnt;
        raw_nx     = raw;
        sclk_nx    = Sclk;
        cs_n_nx    = Cs_n;
        sample_nx  = Audio_Sample;
        valid_nx   = 1'b0;
        // A tick that finds the engine busy is dropped, not queued.
        ovr_nx     = Overrun | (tick && (state != IDLE));

        case (state)
            IDLE: begin
                sclk_nx = 1'b1;
                cs_n_nx = 1'b1;
                if (tick) begin
                    cs_n_nx    = 1'b0;
                    div_cnt_nx = '0;
                    state_nx   = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_cnt_nx = '0;
                    bit_cnt_nx = '0;
                    sclk_nx    = 1'b0;
                    state_nx   = SHIFT;
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_cnt_nx = '0;
                    if (!Sclk) begin
                        // End of low phase: raise Sclk and capture the bit.
                        sclk_nx = 1'b1;
                        raw_nx  = {raw[10:0], Miso};
                    end else if (bit_cnt == 4'd15) begin
                        cs_n_nx  = 1'b1;
                        state_nx = QUIET;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                        sclk_nx    = 1'b0;
                    end
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end
            QUIET: begin
                if (div_end) begin
                    div_cnt_nx = '0;
                    state_nx   = DONE;
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end
            DONE: begin
                sample_nx = result;
                valid_nx  = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mic_adc_capture.sv
// Directed bench for mic_adc_capture with an ADC model shifting on Sclk fall.
// Main DUT: SCLK_DIV=2, SAMPLE_DIV=100; second DUT: SAMPLE_DIV=40 for overrun.
// Expected values follow the MIC_AVG2_EN setting of the build.
module tb_mic_adc_capture;

    logic        Clk;
    logic        Reset, En, Miso;
    logic        Sclk, Cs_n, Sample_Valid, Overrun;
    logic [15:0] Audio_Sample;

    logic        Reset2, En2, Miso2;
    logic        sclk2, cs_n2, valid2, ovr2;
    logic [15:0] sample2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] adc_word;
    int          adc_idx;

    // Monitor state
    int   n_fall = 0, n_sv = 0, t_fall = 0, t_sv = 0;
    int   rises = 0, last_rises = 0, sv_double = 0;
    logic cs_q = 1'b1, sclk_q = 1'b1, sv_q = 1'b0;

    mic_adc_capture #(.SCLK_DIV(2), .SAMPLE_DIV(100)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Miso(Miso),
        .Sclk(Sclk), .Cs_n(Cs_n), .Audio_Sample(Audio_Sample),
        .Sample_Valid(Sample_Valid), .Overrun(Overrun)
    );

    mic_adc_capture #(.SCLK_DIV(2), .SAMPLE_DIV(40)) dut_ovr (
        .Clk(Clk), .Reset(Reset2), .En(En2), .Miso(Miso2),
        .Sclk(sclk2), .Cs_n(cs_n2), .Audio_Sample(sample2),
        .Sample_Valid(valid2), .Overrun(ovr2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // ADC model: restart at bit 15 on Cs_n fall, present next bit on each Sclk fall.
    initial begin
        forever begin
            @(negedge Cs_n);
            adc_idx = 15;
        end
    end

    initial begin
        forever begin
            @(negedge Sclk);
            if (!Cs_n && adc_idx >= 0) begin
                Miso = adc_word[adc_idx];
                adc_idx = adc_idx - 1;
            end
        end
    end

    // Frame monitor, sampled on the inactive clock edge.
    always @(negedge Clk) begin
        if (cs_q && !Cs_n) begin
            t_fall = cyc;
            n_fall = n_fall + 1;
            rises  = 0;
        end
        if (!cs_q && Cs_n)
            last_rises = rises;
        if (!Cs_n && Sclk && !sclk_q)
            rises = rises + 1;
        if (Sample_Valid) begin
            t_sv = cyc;
            n_sv = n_sv + 1;
            if (sv_q)
                sv_double = sv_double + 1;
        end
        cs_q   = Cs_n;
        sclk_q = Sclk;
        sv_q   = Sample_Valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic wait_fall(input int budget);
        int n0 = n_fall;
        int k  = 0;
        while (n_fall == n0 && k < budget) begin
            step(1);
            k++;
        end
        chk("cs_fall_seen", 32'(n_fall != n0), 32'd1);
    endtask

    task automatic wait_sv(input int budget);
        int n0 = n_sv;
        int k  = 0;
        while (n_sv == n0 && k < budget) begin
            step(1);
            k++;
        end
        chk("strobe_seen", 32'(n_sv != n0), 32'd1);
    endtask

    logic [15:0] exp_a, exp_b, exp_c, exp_d;
    int c0, c1, c2, t_prev, sv_base, fall_base;

    initial begin
`ifdef MIC_AVG2_EN
        exp_a = 16'h3FF8; exp_b = 16'h3FF8; exp_c = 16'hC000; exp_d = 16'hD5E0;
`else
        exp_a = 16'h7FF0; exp_b = 16'h0000; exp_c = 16'h8000; exp_d = 16'h2BC0;
`endif
        Reset = 1'b1; En = 1'b1; Miso = 1'b0; adc_word = 16'h0FFF; adc_idx = 15;
        Reset2 = 1'b1; En2 = 1'b1; Miso2 = 1'b0;
        step(3);
        chk("rst_sclk", 32'(Sclk), 32'd1);
        chk("rst_cs_n", 32'(Cs_n), 32'd1);
        chk("rst_sample", 32'(Audio_Sample), 32'h0);
        chk("rst_valid", 32'(Sample_Valid), 32'd0);
        chk("rst_overrun", 32'(Overrun), 32'd0);

        // First tick lands SAMPLE_DIV cycles after release.
        Reset = 1'b0;
        c0 = cyc;
        wait_fall(200);
        chk("first_tick", 32'(t_fall - c0), 32'd100);

        // Reset 30 cycles into the frame, during an Sclk low phase.
        step(30);
        chk("sclk_low_pre", 32'(Sclk), 32'd0);
        #1 Reset = 1'b1;
        #1;
        chk("midrst_sclk", 32'(Sclk), 32'd1);
        chk("midrst_cs_n", 32'(Cs_n), 32'd1);
        step(3);
        chk("midrst_sample", 32'(Audio_Sample), 32'h0);
        chk("midrst_no_sv", 32'(n_sv), 32'd0);
        Reset = 1'b0;
        c1 = cyc;

        // Full-scale word after release.
        wait_sv(300);
        chk("post_rst_latency", 32'(t_sv - c1), 32'd169);
        chk("frame_len", 32'(t_sv - t_fall), 32'd69);
        chk("sample_fs", 32'(Audio_Sample), 32'(exp_a));
        chk("sclk_rises", 32'(last_rises), 32'd16);
        chk("cs_idle_between", 32'(Cs_n), 32'd1);

        // Midscale then zero.
        adc_word = 16'h0800;
        t_prev = t_sv;
        wait_sv(150);
        chk("sample_mid", 32'(Audio_Sample), 32'(exp_b));
        chk("spacing_1", 32'(t_sv - t_prev), 32'd100);
        adc_word = 16'h0000;
        t_prev = t_sv;
        wait_sv(150);
        chk("sample_zero", 32'(Audio_Sample), 32'(exp_c));
        chk("spacing_2", 32'(t_sv - t_prev), 32'd100);

        // En low: no activity.
        En = 1'b0;
        sv_base = n_sv; fall_base = n_fall;
        step(500);
        chk("en0_no_cs", 32'(n_fall - fall_base), 32'd0);
        chk("en0_no_sv", 32'(n_sv - sv_base), 32'd0);

        // En dropped mid-SHIFT: that frame still completes once.
        adc_word = 16'h0ABC;
        En = 1'b1;
        wait_fall(200);
        step(20);
        En = 1'b0;
        step(300);
        chk("endrop_frames", 32'(n_fall - fall_base), 32'd1);
        chk("endrop_strobes", 32'(n_sv - sv_base), 32'd1);
        chk("endrop_sample", 32'(Audio_Sample), 32'(exp_d));
        chk("no_double_sv", 32'(sv_double), 32'd0);
        chk("legal_no_overrun", 32'(Overrun), 32'd0);

        // Too-short sample period: second tick lands mid-frame.
        Reset2 = 1'b0;
        c2 = cyc;
        step(60);
        chk("ovr_after_tick1", 32'(ovr2), 32'd0);
        step(25);
        chk("ovr_after_tick2", 32'(ovr2), 32'd1);
        En2 = 1'b0;
        step(200);
        chk("ovr_sticky", 32'(ovr2), 32'd1);
        Reset2 = 1'b1;
        #1;
        chk("ovr_cleared", 32'(ovr2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
